// File: rtl/reg_file_cmd_ctrl.sv
// UART command sequencer: decodes 0xAA write / 0xBB read frames into register-file strobes and returns read data to TX.
// Optional inter-byte frame timeout enabled by defining CMD_TIMEOUT_EN.
module reg_file_cmd_ctrl #(
  parameter int ADD_WIDTH      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] Rd_DATA,
  input  logic                  Rd_DATA_VLD,
  input  logic                  FIFO_FULL,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADD_WIDTH-1:0]  ADDRESS,
  output logic [DATA_WIDTH-1:0] Wr_DATA,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  BUSY,
  output logic                  TIMEOUT_ERR
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

  state_t                state_q;
  logic                  wren_q, rden_q, txv_q, busy_q;
  logic [ADD_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, txd_q, hold_q;

`ifdef CMD_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q;
  logic          to_err_q;
  logic          timed;
  assign timed = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      txv_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      hold_q  <= '0;
`ifdef CMD_TIMEOUT_EN
      cnt_q    <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      wren_q <= 1'b0;
      rden_q <= 1'b0;
      txv_q  <= 1'b0;
      case (state_q)
        IDLE: if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WR) begin
            state_q <= WR_ADDR;
            busy_q  <= 1'b1;
          end else if (RX_P_DATA == OP_RD) begin
            state_q <= RD_ADDR;
            busy_q  <= 1'b1;
          end
        end
        WR_ADDR: if (RX_D_VLD) begin
          addr_q  <= RX_P_DATA[ADD_WIDTH-1:0];
          state_q <= WR_DATA;
        end
        WR_DATA: if (RX_D_VLD) begin
          wdata_q <= RX_P_DATA;
          wren_q  <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        RD_ADDR: if (RX_D_VLD) begin
          addr_q  <= RX_P_DATA[ADD_WIDTH-1:0];
          rden_q  <= 1'b1;
          state_q <= RD_WAIT;
        end
        // Forward straight to TX when the FIFO has room so TX_D_VLD lands one cycle after Rd_DATA_VLD.
        RD_WAIT: if (Rd_DATA_VLD) begin
          hold_q <= Rd_DATA;
          if (!FIFO_FULL) begin
            txd_q   <= Rd_DATA;
            txv_q   <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= TX_SEND;
          end
        end
        TX_SEND: if (!FIFO_FULL) begin
          txd_q   <= hold_q;
          txv_q   <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
`ifdef CMD_TIMEOUT_EN
      to_err_q <= 1'b0;
      // Abort only fires on a silent cycle, so it never competes with a byte being consumed above.
      if (!timed || RX_D_VLD) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        cnt_q    <= '0;
        to_err_q <= 1'b1;
        state_q  <= IDLE;
        busy_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
`endif
    end
  end

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign ADDRESS   = addr_q;
  assign Wr_DATA   = wdata_q;
  assign TX_P_DATA = txd_q;
  assign TX_D_VLD  = txv_q;
  assign BUSY      = busy_q;

`ifdef CMD_TIMEOUT_EN
  assign TIMEOUT_ERR = to_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign TIMEOUT_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Scoreboard bench for reg_file_cmd_ctrl: expected strobes are queued with their due cycle and matched by a monitor.
module tb_reg_file_cmd_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int KW = 0, KR = 1, KX = 2, KTO = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic [DW-1:0] Rd_DATA = '0;
  logic          Rd_DATA_VLD = 1'b0;
  logic          FIFO_FULL = 1'b0;
  logic          WrEn, RdEn, TX_D_VLD, BUSY, TIMEOUT_ERR;
  logic [AW-1:0] ADDRESS;
  logic [DW-1:0] Wr_DATA, TX_P_DATA;

  reg_file_cmd_ctrl #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Rd_DATA(Rd_DATA), .Rd_DATA_VLD(Rd_DATA_VLD), .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .ADDRESS(ADDRESS), .Wr_DATA(Wr_DATA),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } ev_t;

  ev_t         sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [DW-1:0] mem [16];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] d, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.d = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic expect_evt(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_evt", k, 99);
    end else if (sb[0].kind != k) begin
      chk("evt_kind", k, sb[0].kind);
    end else begin
      e = sb.pop_front();
      chk("evt_cycle", cyc, e.cyc);
      chk("evt_addr", a, e.a);
      chk("evt_data", d, e.d);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    if (!RST) begin
      chk("wr_rd_excl", {31'b0, WrEn & RdEn}, 32'd0);
      if (WrEn)        expect_evt(KW, 32'(ADDRESS), 32'(Wr_DATA));
      if (RdEn)        expect_evt(KR, 32'(ADDRESS), 32'd0);
      if (TX_D_VLD)    expect_evt(KX, 32'd0, 32'(TX_P_DATA));
      if (TIMEOUT_ERR) expect_evt(KTO, 32'd0, 32'd0);
    end
  end

  // Register-file model: returns data one cycle after RdEn.
  always begin
    @(negedge CLK);
    if (RdEn && !RST) begin
      @(posedge CLK);
      #1;
      Rd_DATA     = mem[ADDRESS];
      Rd_DATA_VLD = 1'b1;
      @(posedge CLK);
      #1;
      Rd_DATA_VLD = 1'b0;
    end
  end

  task automatic send_byte(input logic [DW-1:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i * 7);
    mem[1] = 8'h5A;
    mem[2] = 8'h81;
    mem[3] = 8'h20;

    #12;
    chk("rst_wren", {31'b0, WrEn}, 0);
    chk("rst_rden", {31'b0, RdEn}, 0);
    chk("rst_addr", 32'(ADDRESS), 0);
    chk("rst_wdata", 32'(Wr_DATA), 0);
    chk("rst_txv", {31'b0, TX_D_VLD}, 0);
    chk("rst_txd", 32'(TX_P_DATA), 0);
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_toerr", {31'b0, TIMEOUT_ERR}, 0);
    RST = 1'b0;
    idle(2);

    // Write 0x3C to address 5
    send_byte(8'hAA);
    chk("busy_after_op", {31'b0, BUSY}, 1);
    send_byte(8'h05);
    send_byte(8'h3C);
    push(KW, 5, 8'h3C, cyc);
    idle(1);
    chk("busy_after_wr", {31'b0, BUSY}, 0);
    idle(2);

    // Read address 2 -> 0x81 on TX
    send_byte(8'hBB);
    send_byte(8'h02);
    push(KR, 2, 0, cyc);
    push(KX, 0, 8'h81, cyc + 2);
    idle(5);
    chk("busy_after_rd", {31'b0, BUSY}, 0);

    // Backpressure: FIFO full for 20 cycles during read of address 3
    FIFO_FULL = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    push(KR, 3, 0, cyc);
    idle(20);
    chk("busy_bp", {31'b0, BUSY}, 1);
    FIFO_FULL = 1'b0;
    push(KX, 0, 8'h20, cyc + 1);
    idle(4);

    // Illegal opcode is ignored
    send_byte(8'h55);
    idle(2);
    chk("busy_illegal", {31'b0, BUSY}, 0);

    // Opcode-valued bytes as address/data
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hAA);
    push(KW, 32'hB, 8'hAA, cyc);
    idle(3);
    chk("addr_hold", 32'(ADDRESS), 32'hB);

    // Reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h07);
    RST = 1'b1;
    #3;
    chk("midrst_addr", 32'(ADDRESS), 0);
    chk("midrst_busy", {31'b0, BUSY}, 0);
    chk("midrst_wdata", 32'(Wr_DATA), 0);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    send_byte(8'h11);
    idle(3);
    chk("busy_post_rst", {31'b0, BUSY}, 0);

`ifdef CMD_TIMEOUT_EN
    send_byte(8'hAA);
    push(KTO, 0, 0, cyc + 16);
    idle(20);
    chk("busy_after_to", {31'b0, BUSY}, 0);
    send_byte(8'hBB);
    send_byte(8'h01);
    push(KR, 1, 0, cyc);
    push(KX, 0, 8'h5A, cyc + 2);
    idle(5);
`else
    // Partial frame waits indefinitely without a timeout
    send_byte(8'hAA);
    idle(20);
    chk("busy_partial", {31'b0, BUSY}, 1);
    send_byte(8'h04);
    send_byte(8'h99);
    push(KW, 4, 8'h99, cyc);
    idle(3);
`endif

    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
